// File: rtl/router_fifo_pkt.sv
// Packet-aware router output FIFO: each entry carries a header tag and data, and the read side counts down the packet's remaining bytes.
// Optional almost_full/almost_empty flags are built only when ROUTER_FIFO_ALMOST_EN is defined.
module router_fifo_pkt #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int ADD_WIDTH = 4,
  parameter int LEN_LSB   = 2,
  parameter int LEN_W     = 6
`ifdef ROUTER_FIFO_ALMOST_EN
  ,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2
`endif
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 soft_reset,
  input  logic                 write_enb,
  input  logic                 lfd_state,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 read_enb,
  output logic [WIDTH-1:0]     data_out,
  output logic                 full,
  output logic                 empty,
  output logic [ADD_WIDTH:0]   level,
  output logic [LEN_W:0]       pkt_count,
  output logic                 wr_err,
  output logic                 rd_err
`ifdef ROUTER_FIFO_ALMOST_EN
  ,
  output logic                 almost_full,
  output logic                 almost_empty
`endif
);

  localparam logic [ADD_WIDTH:0] PTR_ONE = 1;
  localparam logic [LEN_W:0]     CNT_ONE = 1;

  logic [WIDTH:0]       mem [DEPTH];
  logic [ADD_WIDTH:0]   wr_ptr;
  logic [ADD_WIDTH:0]   rd_ptr;
  logic                 flush;
  logic                 wr_acc;
  logic                 rd_acc;

  assign flush  = reset || soft_reset;
  assign full   = (wr_ptr[ADD_WIDTH] != rd_ptr[ADD_WIDTH]) &&
                  (wr_ptr[ADD_WIDTH-1:0] == rd_ptr[ADD_WIDTH-1:0]);
  assign empty  = (wr_ptr == rd_ptr);
  assign level  = wr_ptr - rd_ptr;
  assign wr_acc = write_enb && !full;
  assign rd_acc = read_enb && !empty;

  // Storage is not reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clock) begin
    if (wr_acc && !flush)
      mem[wr_ptr[ADD_WIDTH-1:0]] <= {lfd_state, data_in};
  end

  always_ff @(posedge clock) begin
    if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      data_out  <= '0;
      pkt_count <= '0;
      wr_err    <= 1'b0;
      rd_err    <= 1'b0;
    end else begin
      wr_err <= write_enb && full;
      rd_err <= read_enb && empty;
      if (wr_acc)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + PTR_ONE;
        data_out <= mem[rd_ptr[ADD_WIDTH-1:0]][WIDTH-1:0];
        // A header reloads with payload length plus the trailing parity byte.
        if (mem[rd_ptr[ADD_WIDTH-1:0]][WIDTH])
          pkt_count <= {1'b0, mem[rd_ptr[ADD_WIDTH-1:0]][LEN_LSB +: LEN_W]} + CNT_ONE;
        else if (pkt_count != '0)
          pkt_count <= pkt_count - CNT_ONE;
      end
    end
  end

`ifdef ROUTER_FIFO_ALMOST_EN
  localparam logic [ADD_WIDTH:0] AFULL_LVL  = (ADD_WIDTH+1)'(AFULL_TH);
  localparam logic [ADD_WIDTH:0] AEMPTY_LVL = (ADD_WIDTH+1)'(AEMPTY_TH);

  assign almost_full  = (level >= AFULL_LVL);
  assign almost_empty = (level <= AEMPTY_LVL);
`endif

endmodule

// File: tb/tb_router_fifo_pkt.sv
// Directed self-checking bench for router_fifo_pkt; checks almost flags too when ROUTER_FIFO_ALMOST_EN is defined.
module tb_router_fifo_pkt;
  logic       clock = 1'b0;
  logic       reset, soft_reset, write_enb, lfd_state, read_enb;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full, empty, wr_err, rd_err;
  logic [4:0] level;
  logic [6:0] pkt_count;
`ifdef ROUTER_FIFO_ALMOST_EN
  logic       almost_full, almost_empty;
`endif

  int vectors = 0;
  int miscompares = 0;

  router_fifo_pkt dut (
    .clock(clock), .reset(reset), .soft_reset(soft_reset),
    .write_enb(write_enb), .lfd_state(lfd_state), .data_in(data_in),
    .read_enb(read_enb), .data_out(data_out), .full(full), .empty(empty),
    .level(level), .pkt_count(pkt_count), .wr_err(wr_err), .rd_err(rd_err)
`ifdef ROUTER_FIFO_ALMOST_EN
    , .almost_full(almost_full), .almost_empty(almost_empty)
`endif
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    write_enb = 1'b0; read_enb = 1'b0; lfd_state = 1'b0; soft_reset = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic hdr);
    write_enb = 1'b1; read_enb = 1'b0; lfd_state = hdr; data_in = d;
    step();
    idle();
  endtask

  initial begin
    reset = 1'b1; soft_reset = 1'b0; write_enb = 1'b0; read_enb = 1'b0;
    lfd_state = 1'b0; data_in = 8'h00;
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_level", level, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_pkt_count", pkt_count, 0);
`ifdef ROUTER_FIFO_ALMOST_EN
    chk("rst_almost_empty", almost_empty, 1);
    chk("rst_almost_full", almost_full, 0);
`endif

    // Fill to 16 entries
    for (int i = 0; i < 16; i++) begin
      write_enb = 1'b1; lfd_state = 1'b0; data_in = 8'h10 + 8'(i);
      step();
      chk("fill_level", level, i + 1);
`ifdef ROUTER_FIFO_ALMOST_EN
      chk("fill_almost_full", almost_full, (i + 1 >= 14) ? 1 : 0);
      chk("fill_almost_empty", almost_empty, (i + 1 <= 2) ? 1 : 0);
`endif
    end
    chk("fill_full", full, 1);
    chk("fill_empty", empty, 0);
    chk("fill_no_wr_err", wr_err, 0);
    data_in = 8'hEE;
    step();
    chk("ovf_wr_err", wr_err, 1);
    chk("ovf_level", level, 16);
    idle();
    step();
    chk("ovf_wr_err_clear", wr_err, 0);

    // Drain in order
    for (int i = 0; i < 16; i++) begin
      read_enb = 1'b1;
      step();
      chk("drain_data", data_out, 32'h10 + 32'(i));
      chk("drain_level", level, 15 - i);
    end
    idle();
    chk("drain_empty", empty, 1);
    chk("drain_rd_err", rd_err, 0);

    // Underflow holds data_out
    read_enb = 1'b1;
    step();
    chk("udf_rd_err", rd_err, 1);
    chk("udf_data_hold", data_out, 8'h1F);
    chk("udf_level", level, 0);
    idle();
    step();
    chk("udf_rd_err_clear", rd_err, 0);

    // Read+write while empty: only the write happens
    read_enb = 1'b1; write_enb = 1'b1; data_in = 8'h77;
    step();
    idle();
    chk("rw_empty_rd_err", rd_err, 1);
    chk("rw_empty_level", level, 1);
    chk("rw_empty_data_hold", data_out, 8'h1F);
    read_enb = 1'b1;
    step();
    idle();
    chk("rw_empty_readback", data_out, 8'h77);

    // Packet count: header len=3, then 3 payload bytes and parity
    push(8'h0C, 1'b1);
    push(8'hA1, 1'b0);
    push(8'hA2, 1'b0);
    push(8'hA3, 1'b0);
    push(8'h55, 1'b0);
    chk("pkt_level", level, 5);
    begin
      logic [7:0] pdat [5];
      logic [6:0] pcnt [5];
      pdat = '{8'h0C, 8'hA1, 8'hA2, 8'hA3, 8'h55};
      pcnt = '{7'd4, 7'd3, 7'd2, 7'd1, 7'd0};
      for (int i = 0; i < 5; i++) begin
        read_enb = 1'b1;
        step();
        chk("pkt_data", data_out, pdat[i]);
        chk("pkt_count", pkt_count, pcnt[i]);
      end
    end
    idle();

    // Soft reset at level 5 with requests pending
    push(8'h14, 1'b1);
    push(8'hB1, 1'b0);
    push(8'hB2, 1'b0);
    push(8'hB3, 1'b0);
    push(8'hB4, 1'b0);
    push(8'hB5, 1'b0);
    read_enb = 1'b1;
    step();
    idle();
    chk("srst_pre_level", level, 5);
    chk("srst_pre_pkt_count", pkt_count, 6);
    chk("srst_pre_data", data_out, 8'h14);
    soft_reset = 1'b1; write_enb = 1'b1; read_enb = 1'b1; data_in = 8'hCC;
    step();
    idle();
    chk("srst_empty", empty, 1);
    chk("srst_full", full, 0);
    chk("srst_level", level, 0);
    chk("srst_data_out", data_out, 0);
    chk("srst_pkt_count", pkt_count, 0);

    // Wrap with concurrent read/write at level 8
    for (int i = 0; i < 8; i++) push(8'h80 + 8'(i), 1'b0);
    chk("wrap_pre_level", level, 8);
    for (int k = 0; k < 40; k++) begin
      write_enb = 1'b1; read_enb = 1'b1; lfd_state = 1'b0; data_in = 8'h88 + 8'(k);
      step();
      chk("wrap_data", data_out, 32'h80 + 32'(k));
      chk("wrap_level", level, 8);
      chk("wrap_errs", {wr_err, rd_err}, 0);
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      read_enb = 1'b1;
      step();
      chk("wrap_tail", data_out, 32'hA8 + 32'(i));
    end
    idle();
    chk("wrap_end_empty", empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
